// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered write-back stage: write-data select, load extraction, retire counter
//
// Purpose: captures one memory-stage entry per cycle into a flushable, stallable
// pipeline register that drives the register-file write port. Write data is
// selected from ALU result, extracted load data, pc+PC_INC or the immediate.
// Misaligned loads are captured with their write enable cleared and reported
// with a one-cycle misalign_err pulse. instret counts released entries.
//
// Ports:
//   clk, rstn                clock, asynchronous active-low reset
//   in_valid / in_ready      memory-stage handshake (in_ready = ~stall)
//   stall, flush             hazard-unit hold and kill of the held entry
//   wdsel, reg_we, rd        write-data select, write request, destination
//   aluout, dout, pc, imm    write-data sources (dout is the raw aligned word)
//   dmtype, addr_lo          load type and byte offset within the word
//   wb_valid, wb_we, wb_rd, wb_wd   registered entry and register-file write port
//   misalign_err             one-cycle pulse after a misaligned load is captured
//   instret                  64-bit retired-instruction count
module wb_stage #(
    parameter int XLEN   = 32,
    parameter int PC_INC = 4,
    parameter int OFFW   = $clog2(XLEN/8)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            stall,
    input  logic            flush,
    input  logic [1:0]      wdsel,
    input  logic            reg_we,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] aluout,
    input  logic [XLEN-1:0] dout,
    input  logic [2:0]      dmtype,
    input  logic [OFFW-1:0] addr_lo,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_wd,
    output logic            misalign_err,
    output logic [63:0]     instret
);

    localparam bit IS64 = (XLEN == 64);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wd;
    logic [1:0]      ld_size;      // 0 byte, 1 half, 2 word, 3 double
    logic            ld_unsigned;
    logic            mis;
    logic            cap_we;
    logic            cap_mis;

    assign in_ready = ~stall;
    assign shifted  = dout >> {addr_lo, 3'b000};

    // Access size and extension; ld/lwu fold onto lw on a 32-bit datapath and
    // the unused 111 encoding is treated as lw.
    always_comb begin
        ld_size     = 2'd2;
        ld_unsigned = 1'b0;
        case (dmtype)
            3'b000: ld_size = 2'd0;
            3'b001: ld_size = 2'd1;
            3'b010: ld_size = 2'd2;
            3'b011: ld_size = IS64 ? 2'd3 : 2'd2;
            3'b100: begin ld_size = 2'd0; ld_unsigned = 1'b1; end
            3'b101: begin ld_size = 2'd1; ld_unsigned = 1'b1; end
            3'b110: begin ld_size = 2'd2; ld_unsigned = 1'b1; end
            default: ld_size = 2'd2;
        endcase
    end

    // Fill with the sign (or zero) first, then overlay the extracted field;
    // this avoids zero-width replications when the field is the full width.
    always_comb begin
        load_data = '0;
        case (ld_size)
            2'd0: begin
                load_data      = {XLEN{~ld_unsigned & shifted[7]}};
                load_data[7:0] = shifted[7:0];
            end
            2'd1: begin
                load_data       = {XLEN{~ld_unsigned & shifted[15]}};
                load_data[15:0] = shifted[15:0];
            end
            2'd2: begin
                load_data       = {XLEN{~ld_unsigned & shifted[31]}};
                load_data[31:0] = shifted[31:0];
            end
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        mis = 1'b0;
        if (wdsel == 2'b01) begin
            case (ld_size)
                2'd1:    mis = addr_lo[0];
                2'd2:    mis = (addr_lo[1:0] != 2'b00);
                2'd3:    mis = (addr_lo != '0);
                default: mis = 1'b0;
            endcase
        end
    end

    always_comb begin
        wd = aluout;
        case (wdsel)
            2'b00:   wd = aluout;
            2'b01:   wd = load_data;
            2'b10:   wd = pc + XLEN'(PC_INC);
            default: wd = imm;
        endcase
    end

    // x0 is never written, regardless of what was captured.
    assign wb_we = wb_valid & cap_we & (wb_rd != 5'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_valid     <= 1'b0;
            cap_we       <= 1'b0;
            cap_mis      <= 1'b0;
            wb_rd        <= 5'd0;
            wb_wd        <= '0;
            misalign_err <= 1'b0;
            instret      <= 64'd0;
        end else begin
            if (wb_valid && !stall && !flush && !cap_mis)
                instret <= instret + 64'd1;

            if (flush) begin
                wb_valid     <= 1'b0;
                misalign_err <= 1'b0;
            end else if (stall) begin
                misalign_err <= 1'b0;
            end else if (in_valid) begin
                wb_valid     <= 1'b1;
                cap_we       <= reg_we & ~mis;
                cap_mis      <= mis;
                wb_rd        <= rd;
                wb_wd        <= wd;
                misalign_err <= mis;
            end else begin
                wb_valid     <= 1'b0;
                misalign_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage (XLEN=32 and XLEN=64)
module tb_wb_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic        rstn;
    logic        in_valid;
    logic        stall;
    logic        flush;
    logic [1:0]  wdsel;
    logic        reg_we;
    logic [4:0]  rd;
    logic [2:0]  dmtype;

    logic [31:0] aluout, dout, pc, imm;
    logic [1:0]  addr_lo;
    logic        in_ready, wb_valid, wb_we, misalign_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic [63:0] instret;

    logic [63:0] aluout64, dout64, pc64, imm64;
    logic [2:0]  addr_lo64;
    logic        in_ready64, wb_valid64, wb_we64, misalign_err64;
    logic [4:0]  wb_rd64;
    logic [63:0] wb_wd64;
    logic [63:0] instret64;

    wb_stage #(.XLEN(32)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .stall(stall), .flush(flush), .wdsel(wdsel), .reg_we(reg_we), .rd(rd),
        .aluout(aluout), .dout(dout), .dmtype(dmtype), .addr_lo(addr_lo),
        .pc(pc), .imm(imm), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_wd(wb_wd), .misalign_err(misalign_err), .instret(instret)
    );

    wb_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready64),
        .stall(stall), .flush(flush), .wdsel(wdsel), .reg_we(reg_we), .rd(rd),
        .aluout(aluout64), .dout(dout64), .dmtype(dmtype), .addr_lo(addr_lo64),
        .pc(pc64), .imm(imm64), .wb_valid(wb_valid64), .wb_we(wb_we64), .wb_rd(wb_rd64),
        .wb_wd(wb_wd64), .misalign_err(misalign_err64), .instret(instret64)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic we,
                         input logic [4:0] r, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] dm, input logic [1:0] lo,
                         input logic [31:0] p, input logic [31:0] im);
        in_valid = v; wdsel = sel; reg_we = we; rd = r; aluout = a; dout = d;
        dmtype = dm; addr_lo = lo; pc = p; imm = im;
    endtask

    task automatic test_reset();
        rstn = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 2'b01, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'h1234_5678, 3'b010, 2'd1, 32'h100, 32'h5);
        aluout64 = '0; dout64 = '0; pc64 = '0; imm64 = '0; addr_lo64 = '0;
        cyc(); cyc();
        tests_run++; if (wb_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_valid got %b expected 0", wb_valid); end
        tests_run++; if (wb_we !== 1'b0) begin tests_failed++; $display("FAIL reset_wb_we got %b expected 0", wb_we); end
        tests_run++; if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL reset_misalign got %b expected 0", misalign_err); end
        tests_run++; if (wb_rd !== 5'd0) begin tests_failed++; $display("FAIL reset_wb_rd got %0d expected 0", wb_rd); end
        tests_run++; if (wb_wd !== 32'd0) begin tests_failed++; $display("FAIL reset_wb_wd got %h expected 0", wb_wd); end
        tests_run++; if (instret !== 64'd0) begin tests_failed++; $display("FAIL reset_instret got %0d expected 0", instret); end
        rstn = 1'b1;
        drive(1'b1, 2'b00, 1'b1, 5'd5, 32'h1234, 32'h0, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc();
        tests_run++; if (wb_we !== 1'b1) begin tests_failed++; $display("FAIL first_wb_we got %b expected 1", wb_we); end
        tests_run++; if (wb_rd !== 5'd5) begin tests_failed++; $display("FAIL first_wb_rd got %0d expected 5", wb_rd); end
        tests_run++; if (wb_wd !== 32'h0000_1234) begin tests_failed++; $display("FAIL first_wb_wd got %h expected 00001234", wb_wd); end
        tests_run++; if (instret !== 64'd0) begin tests_failed++; $display("FAIL first_instret got %0d expected 0", instret); end
    endtask

    task automatic test_loads();
        logic [2:0]  dm_t  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [1:0]  lo_t  [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp_t [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b01, 1'b1, 5'd3, 32'h0, 32'h80FF_7F01, dm_t[i], lo_t[i], 32'h0, 32'h0);
            cyc();
            tests_run++;
            if (wb_wd !== exp_t[i] || wb_we !== 1'b1) begin
                tests_failed++;
                $display("FAIL load_%0d got wd=%h we=%b expected wd=%h we=1", i, wb_wd, wb_we, exp_t[i]);
            end
        end
        tests_run++; if (instret !== 64'd5) begin tests_failed++; $display("FAIL load_instret got %0d expected 5", instret); end
    endtask

    task automatic test_misalign_and_selects();
        drive(1'b1, 2'b01, 1'b1, 5'd4, 32'h0, 32'h80FF_7F01, 3'b010, 2'd1, 32'h0, 32'h0);
        cyc();
        tests_run++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin tests_failed++; $display("FAIL mis_capture got valid=%b we=%b expected valid=1 we=0", wb_valid, wb_we); end
        tests_run++; if (misalign_err !== 1'b1) begin tests_failed++; $display("FAIL mis_pulse got %b expected 1", misalign_err); end
        tests_run++; if (instret !== 64'd6) begin tests_failed++; $display("FAIL mis_instret_a got %0d expected 6", instret); end
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc();
        tests_run++; if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse_end got %b expected 0", misalign_err); end
        tests_run++; if (instret !== 64'd6) begin tests_failed++; $display("FAIL mis_not_counted got %0d expected 6", instret); end
        drive(1'b1, 2'b10, 1'b1, 5'd1, 32'h0, 32'h0, 3'b010, 2'd0, 32'hFFFF_FFFC, 32'h0);
        cyc();
        tests_run++; if (wb_wd !== 32'h0) begin tests_failed++; $display("FAIL link_wrap got %h expected 00000000", wb_wd); end
        drive(1'b1, 2'b11, 1'b1, 5'd2, 32'h0, 32'h0, 3'b010, 2'd0, 32'h0, 32'hABCD_E000);
        cyc();
        tests_run++; if (wb_wd !== 32'hABCD_E000) begin tests_failed++; $display("FAIL imm_select got %h expected abcde000", wb_wd); end
        tests_run++; if (instret !== 64'd7) begin tests_failed++; $display("FAIL sel_instret got %0d expected 7", instret); end
    endtask

    task automatic test_x0();
        drive(1'b1, 2'b00, 1'b1, 5'd0, 32'hDEAD, 32'h0, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc();
        tests_run++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin tests_failed++; $display("FAIL x0_suppress got valid=%b we=%b expected valid=1 we=0", wb_valid, wb_we); end
        drive(1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc();
        tests_run++; if (instret !== 64'd9) begin tests_failed++; $display("FAIL x0_counted got %0d expected 9", instret); end
    endtask

    task automatic test_stall_flush();
        drive(1'b1, 2'b00, 1'b1, 5'd7, 32'h11, 32'h0, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc();
        tests_run++; if (wb_rd !== 5'd7 || wb_wd !== 32'h11 || wb_we !== 1'b1) begin tests_failed++; $display("FAIL entry_a got rd=%0d wd=%h we=%b expected rd=7 wd=11 we=1", wb_rd, wb_wd, wb_we); end
        drive(1'b1, 2'b00, 1'b1, 5'd9, 32'h22, 32'h0, 3'b010, 2'd0, 32'h0, 32'h0);
        stall = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL in_ready_stall got %b expected 0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests_run++;
            if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_wd !== 32'h11 || instret !== 64'd9) begin
                tests_failed++;
                $display("FAIL stall_hold_%0d got valid=%b rd=%0d wd=%h instret=%0d expected 1/7/11/9", i, wb_valid, wb_rd, wb_wd, instret);
            end
        end
        flush = 1'b1;
        cyc();
        tests_run++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin tests_failed++; $display("FAIL flush_kill got valid=%b we=%b expected 0/0", wb_valid, wb_we); end
        flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL in_ready_free got %b expected 1", in_ready); end
        cyc();
        tests_run++; if (instret !== 64'd9) begin tests_failed++; $display("FAIL flush_not_counted got %0d expected 9", instret); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 2'b00, 1'b1, 5'd1, 32'h5, 32'h0, 3'b010, 2'd0, 32'h0, 32'h0);
        cyc();
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        in_valid = 1'b0;
        cyc();
        tests_run++; if (instret !== 64'd0) begin tests_failed++; $display("FAIL instret_wrap got %h expected 0", instret); end
    endtask

    task automatic test_xlen64();
        logic [2:0]  dm_t  [3] = '{3'b011, 3'b110, 3'b010};
        logic [2:0]  lo_t  [3] = '{3'd0, 3'd4, 3'd4};
        logic [63:0] exp_t [3] = '{64'hFEDC_BA98_7654_3210, 64'h0000_0000_FEDC_BA98, 64'hFFFF_FFFF_FEDC_BA98};
        dout64 = 64'hFEDC_BA98_7654_3210;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b01, 1'b1, 5'd6, 32'h0, 32'h0, dm_t[i], 2'd0, 32'h0, 32'h0);
            addr_lo64 = lo_t[i];
            cyc();
            tests_run++;
            if (wb_wd64 !== exp_t[i] || wb_we64 !== 1'b1 || misalign_err64 !== 1'b0) begin
                tests_failed++;
                $display("FAIL x64_load_%0d got wd=%h we=%b mis=%b expected wd=%h we=1 mis=0", i, wb_wd64, wb_we64, misalign_err64, exp_t[i]);
            end
        end
        drive(1'b1, 2'b01, 1'b1, 5'd6, 32'h0, 32'h0, 3'b011, 2'd0, 32'h0, 32'h0);
        addr_lo64 = 3'd4;
        cyc();
        tests_run++; if (misalign_err64 !== 1'b1 || wb_we64 !== 1'b0) begin tests_failed++; $display("FAIL x64_ld_misalign got mis=%b we=%b expected mis=1 we=0", misalign_err64, wb_we64); end
        in_valid = 1'b0;
        cyc();
        tests_run++; if (misalign_err64 !== 1'b0) begin tests_failed++; $display("FAIL x64_mis_end got %b expected 0", misalign_err64); end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_misalign_and_selects();
        test_x0();
        test_stall_flush();
        test_wrap();
        test_xlen64();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Registered write-back stage for the pipelined RISC-V core, replacing the single-cycle write-data select. It accepts one instruction per cycle from the memory stage and chooses the register-file write data from ALU result, load data, PC+4 or immediate. It extracts and sign- or zero-extends sub-word loads, and drops misaligned loads. It drives the register-file write port from a flushable, stallable pipeline register and counts retired instructions.

## Interface
- XLEN, 32: datapath width; legal values 32, 64.
- PC_INC, 4: increment added to pc for the link value.
- OFFW, $clog2(XLEN/8): width of the byte-offset field.

- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- in_valid  in  1  memory-stage entry valid.
- in_ready  out  1  stage accepts this cycle; equals ~stall.
- stall  in  1  hazard unit hold; pipeline register keeps its contents.
- flush  in  1  kill the held entry.
- wdsel  in  2  00 ALU, 01 MEM, 10 PC+PC_INC, 11 IMM.
- reg_we  in  1  instruction writes rd.
- rd  in  5  destination register.
- aluout  in  XLEN  ALU result.
- dout  in  XLEN  raw aligned memory word.
- dmtype  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu.
- addr_lo  in  OFFW  low bits of the load address.
- pc  in  XLEN  instruction PC.
- imm  in  XLEN  extended immediate.
- wb_valid  out  1  registered entry valid.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- wb_wd  out  XLEN  register-file write data.
- misalign_err  out  1  one-cycle pulse for a misaligned load entering the stage.
- instret  out  64  retired-instruction count.

## Operation
- Write data is computed combinationally from the inputs and captured into the pipeline register.
- Load extraction for wdsel=01:
  - Shift dout right by 8*addr_lo.
  - Take the low 8, 16, 32 or 64 bits per dmtype.
  - Sign-extend for lb, lh, lw; zero-extend for lbu, lhu, lwu.
  - When XLEN=32: ld and lwu behave as lw; offset field is 2 bits.
  - dmtype 111 behaves as lw.
- Misalignment applies only when wdsel=01:
  - lh or lhu with addr_lo[0]=1.
  - lw or lwu with addr_lo[1:0]≠0.
  - ld with addr_lo≠0.
  - A misaligned entry is still captured, with its write enable cleared.
  - misalign_err is registered, asserts in the capture cycle +1, and lasts one cycle.
- wdsel=10: link value is pc+PC_INC, modulo 2^XLEN.
- Register update priority on each clk edge:
  1. flush: wb_valid←0. Other fields are don't-care, but wb_we must read 0. Applies even when stall=1.
  2. stall: all fields hold; misalign_err←0.
  3. in_valid: capture rd, write enable, data; wb_valid←1.
  4. otherwise: wb_valid←0.
- wb_we = wb_valid & captured_we & (wb_rd≠0). x0 is never written.
- instret increments by 1 on each edge where wb_valid=1 and the entry is released.
  - Released means not stalled and not flushed.
  - Misaligned entries do not count.
  - Wraps 2^64−1→0.

## Timing
- Reset (rstn=0, asynchronous): wb_valid, wb_we, misalign_err = 0; wb_rd = 0; wb_wd = 0; instret = 0.
- Reset deassertion: first capture occurs on the first rising edge with rstn=1.
- Latency: inputs presented in cycle N appear on wb_* in cycle N+1. Throughput is one entry per cycle.
- in_ready is combinational from stall only; no dependence on in_valid.
- Simultaneous flush and in_valid: the incoming entry is discarded.
- Simultaneous stall and in_valid: the input is not taken; the upstream stage must hold it.
- Mid-operation reset discards the held entry and clears instret immediately, without waiting for a clock.

## Test plan
- Reset: hold rstn=0 with active inputs → all outputs 0. Release rstn; then wdsel=00, aluout=0x1234, rd=5, reg_we=1 → next cycle wb_we=1, wb_rd=5, wb_wd=0x00001234.
- Load extraction, dout=0x80FF7F01:
  - lb, addr_lo=3 → wb_wd=0xFFFFFF80.
  - lbu, addr_lo=3 → 0x00000080.
  - lh, addr_lo=2 → 0xFFFF80FF.
  - lhu, addr_lo=0 → 0x00007F01.
  - lw, addr_lo=0 → 0x80FF7F01.
- Misaligned and other selects:
  - lw with addr_lo=1 → wb_valid=1, wb_we=0, misalign_err pulses once, instret unchanged.
  - wdsel=10, pc=0xFFFFFFFC → wb_wd=0x00000000.
  - wdsel=11, imm=0xABCDE000 → wb_wd=0xABCDE000.
- x0 suppression: reg_we=1, rd=0, aluout=0xDEAD → wb_valid=1, wb_we=0, instret increments.
- Stall, then flush: capture entry A (rd=7, data 0x11), then stall 3 cycles with a new entry B presented → wb_* holds A for 3 cycles, in_ready=0, instret unchanged. Then assert flush together with stall → wb_valid=0 next cycle, A is never counted.
- XLEN=64 instance:
  - dout=0xFEDCBA9876543210, ld, addr_lo=0 → wb_wd=0xFEDCBA9876543210.
  - lwu, addr_lo=4 → 0x00000000FEDCBA98.
  - lw, addr_lo=4 → 0xFFFFFFFFFEDCBA98.
  - ld, addr_lo=4 → misalign_err pulses.
- Counter wrap (forced preload): instret=2^64−1 plus one release → 0.
